imgpre_frame_ctrl: RTL

Frame sequencer that feeds the imgpreProcess grayscale/Gaussian pipeline from an upstream RGB pixel stream.
- Latches frame geometry and gates input into whole lines.
- Enforces inter-line idle gaps and appends flush lines so the 3-line filter window empties.
- Counts processed output pixels and pulses frame completion.
- Sits between the camera/DMA source and imgpreProcess; imgpreProcess receives pp_* directly.

---
 rtl/imgpre_frame_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/imgpre_frame_ctrl.sv
// Frame sequencer in front of the imgpreProcess pipeline: gates RGB input into whole lines,
// inserts idle gaps and flush lines, counts output pixels. Optional macro: IMGPRE_DRAIN_TIMEOUT_EN.
module imgpre_frame_ctrl #(
  parameter int         GAP_CYCLES    = 2,
  parameter int         FLUSH_LINES   = 2,
  parameter logic [7:0] PAD_VALUE     = 8'd0,
  parameter int         DRAIN_TIMEOUT = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] img_width,
  input  logic [11:0] img_height,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_r,
  input  logic [7:0]  s_g,
  input  logic [7:0]  s_b,
  output logic        pp_din_valid,
  output logic [7:0]  pp_r,
  output logic [7:0]  pp_g,
  output logic [7:0]  pp_b,
  output logic [11:0] pp_img_width,
  input  logic        pp_dout_valid,
`ifdef IMGPRE_DRAIN_TIMEOUT_EN
  output logic        err_timeout,
`endif
  output logic        busy,
  output logic        frame_done,
  output logic        err_cfg,
  output logic [23:0] out_cnt,
  output logic [11:0] line_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_LINE, S_GAP, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  generate
    if (GAP_CYCLES < 1 || FLUSH_LINES < 0 || DRAIN_TIMEOUT < 1) begin : g_bad_cfg
      $error("imgpre_frame_ctrl: GAP_CYCLES and DRAIN_TIMEOUT must be >= 1");
    end
  endgenerate

  state_t      state, next_state;
  logic [11:0] h_q;
  logic [11:0] pix_cnt;
  logic [15:0] gap_cnt;

  logic        cfg_ok, accept, hs, last_pix, gap_last, drain_done;
  logic [12:0] line_ext, h_ext, flush_end;
  logic [23:0] frame_pix;

  assign s_ready    = (state == S_LINE);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  assign cfg_ok     = (img_width >= 12'd3) && (img_height >= 12'd3);
  assign accept     = (state == S_IDLE) && start && cfg_ok;
  assign hs         = s_valid && s_ready;
  assign last_pix   = (pix_cnt == pp_img_width - 12'd1);
  assign gap_last   = (gap_cnt == 16'(GAP_CYCLES - 1));
  assign line_ext   = {1'b0, line_idx};
  assign h_ext      = {1'b0, h_q};
  assign flush_end  = h_ext + 13'(FLUSH_LINES);
  assign frame_pix  = 24'(pp_img_width) * 24'(h_q);
  assign drain_done = (out_cnt >= frame_pix);

`ifdef IMGPRE_DRAIN_TIMEOUT_EN
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  logic [DW-1:0] drain_cnt;
  logic          drain_expired;

  assign drain_expired = (drain_cnt == DW'(DRAIN_TIMEOUT - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state gets its default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_LINE;
      S_LINE:  if (hs && last_pix) next_state = S_GAP;
      S_GAP: begin
        if (gap_last) begin
          if (line_ext < h_ext)          next_state = S_LINE;
          else if (line_ext < flush_end) next_state = S_FLUSH;
          else                           next_state = S_DRAIN;
        end
      end
      S_FLUSH: if (last_pix) next_state = S_GAP;
      S_DRAIN: begin
        if (drain_done) next_state = S_DONE;
`ifdef IMGPRE_DRAIN_TIMEOUT_EN
        else if (drain_expired) next_state = S_DONE;
`endif
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_din_valid <= 1'b0;
      pp_r         <= 8'd0;
      pp_g         <= 8'd0;
      pp_b         <= 8'd0;
      pp_img_width <= 12'd0;
      h_q          <= 12'd0;
      err_cfg      <= 1'b0;
      line_idx     <= 12'd0;
      pix_cnt      <= 12'd0;
      gap_cnt      <= 16'd0;
    end else begin
      pp_din_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              pp_img_width <= img_width;
              h_q          <= img_height;
              err_cfg      <= 1'b0;
              line_idx     <= 12'd0;
              pix_cnt      <= 12'd0;
              gap_cnt      <= 16'd0;
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end
        S_LINE: begin
          if (hs) begin
            pp_din_valid <= 1'b1;
            pp_r         <= s_r;
            pp_g         <= s_g;
            pp_b         <= s_b;
            if (last_pix) begin
              pix_cnt  <= 12'd0;
              line_idx <= line_idx + 12'd1;
              gap_cnt  <= 16'd0;
            end else begin
              pix_cnt <= pix_cnt + 12'd1;
            end
          end
        end
        S_GAP: gap_cnt <= gap_last ? 16'd0 : gap_cnt + 16'd1;
        S_FLUSH: begin
          pp_din_valid <= 1'b1;
          pp_r         <= PAD_VALUE;
          pp_g         <= PAD_VALUE;
          pp_b         <= PAD_VALUE;
          if (last_pix) begin
            pix_cnt  <= 12'd0;
            line_idx <= line_idx + 12'd1;
            gap_cnt  <= 16'd0;
          end else begin
            pix_cnt <= pix_cnt + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output pixels are only meaningful inside a frame; the count holds after DONE for inspection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       out_cnt <= 24'd0;
    else if (accept)                                  out_cnt <= 24'd0;
    else if (busy && pp_dout_valid && out_cnt != '1) out_cnt <= out_cnt + 24'd1;
  end

`ifdef IMGPRE_DRAIN_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + DW'(1) : '0;
      if (accept)
        err_timeout <= 1'b0;
      else if (state == S_DRAIN && !drain_done && drain_expired)
        err_timeout <= 1'b1;
    end
  end
`endif

endmodule
